// File: rtl/epb_pkg.sv
// Shared definitions for the Wishbone-to-EPB master bridge: FSM encoding, bus widths and the
// default response timeout.
package epb_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StActive  = 2'd1,
    StRecover = 2'd2
  } epb_state_e;

  localparam int unsigned EPB_ADDR_W      = 25;
  localparam int unsigned EPB_DATA_W      = 32;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/epb_timeout_ctr.sv
// Cycle counter for the EPB wait: cleared when a request is accepted, counts while the
// transaction is active, and flags the last permitted cycle.
module epb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  // No saturation here: the FSM always leaves ACTIVE on the expiring cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == CntLast);

endmodule

// File: rtl/wb_epb_master.sv
// Wishbone slave that turns each single Wishbone cycle into one EPB master transaction,
// ending it on epb_rdy or with a Wishbone error after a bounded wait.
module wb_epb_master
  import epb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  epb_cs_n,
  output logic                  epb_oe_n,
  output logic                  epb_r_w_n,
  output logic [3:0]            epb_be_n,
  output logic [5:29]           epb_addr,
  output logic [0:31]           epb_data_o,
  output logic                  epb_data_oe_n,
  input  logic [0:31]           epb_data_i,
  input  logic                  epb_rdy
);

  epb_state_e state_q, state_d;

  logic                  cs_n_d, oe_n_d, r_w_n_d, data_oe_n_d;
  logic [3:0]            be_n_d;
  logic [EPB_ADDR_W-1:0] addr_d;
  logic [EPB_DATA_W-1:0] dout_d, rdat_d;
  logic                  ack_d, err_d;
  logic                  ctr_clear, ctr_en, expired;

  // Only the word address within the EPB window is forwarded.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:27], wb_adr_i[1:0]};

  epb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (ctr_clear),
    .enable (ctr_en),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    cs_n_d      = epb_cs_n;
    oe_n_d      = epb_oe_n;
    r_w_n_d     = epb_r_w_n;
    data_oe_n_d = epb_data_oe_n;
    be_n_d      = epb_be_n;
    addr_d      = epb_addr;
    dout_d      = epb_data_o;
    rdat_d      = wb_dat_o;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    ctr_clear   = 1'b0;
    ctr_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_d      = wb_adr_i[26:2];
          be_n_d      = ~wb_sel_i;
          r_w_n_d     = ~wb_we_i;
          dout_d      = wb_dat_i;
          cs_n_d      = 1'b0;
          oe_n_d      = wb_we_i;
          data_oe_n_d = ~wb_we_i;
          ctr_clear   = 1'b1;
          state_d     = StActive;
        end
      end
      StActive: begin
        ctr_en = 1'b1;
        // epb_rdy takes priority over a simultaneous expiry.
        if (epb_rdy) begin
          if (epb_r_w_n) rdat_d = epb_data_i;
          ack_d       = wb_cyc_i;
          cs_n_d      = 1'b1;
          oe_n_d      = 1'b1;
          data_oe_n_d = 1'b1;
          state_d     = StRecover;
        end else if (expired) begin
          err_d       = wb_cyc_i;
          cs_n_d      = 1'b1;
          oe_n_d      = 1'b1;
          data_oe_n_d = 1'b1;
          state_d     = StRecover;
        end
      end
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= StIdle;
      epb_cs_n      <= 1'b1;
      epb_oe_n      <= 1'b1;
      epb_r_w_n     <= 1'b1;
      epb_data_oe_n <= 1'b1;
      epb_be_n      <= 4'hF;
      epb_addr      <= '0;
      epb_data_o    <= '0;
      wb_dat_o      <= '0;
      wb_ack_o      <= 1'b0;
      wb_err_o      <= 1'b0;
    end else begin
      state_q       <= state_d;
      epb_cs_n      <= cs_n_d;
      epb_oe_n      <= oe_n_d;
      epb_r_w_n     <= r_w_n_d;
      epb_data_oe_n <= data_oe_n_d;
      epb_be_n      <= be_n_d;
      epb_addr      <= addr_d;
      epb_data_o    <= dout_d;
      wb_dat_o      <= rdat_d;
      wb_ack_o      <= ack_d;
      wb_err_o      <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_epb_master.sv
// Self-checking bench for wb_epb_master: directed scenarios plus randomized transactions
// checked against a transaction-level model of the bridge.
module tb_wb_epb_master;

  localparam int TO = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic        epb_cs_n, epb_oe_n, epb_r_w_n, epb_data_oe_n;
  logic [3:0]  epb_be_n;
  logic [5:29] epb_addr;
  logic [0:31] epb_data_o;
  logic [0:31] epb_data_i;
  logic        epb_rdy;

  int checks = 0;
  int errors = 0;

  // Transaction observations filled by do_xfer.
  int          ack_k, err_k, n_ack, n_err;
  logic [31:0] dat_at_ack, dat_at_end;
  logic        cs_at_done;
  logic        s_cs, s_oe, s_doe, s_rw;
  logic [3:0]  s_be;
  logic [24:0] s_addr;
  logic [31:0] s_dout;

  // Model of the read-data register as seen by Wishbone.
  logic [31:0] model_dat;

  wb_epb_master #(
    .TIMEOUT(TO)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .wb_cyc_i     (wb_cyc_i),
    .wb_stb_i     (wb_stb_i),
    .wb_we_i      (wb_we_i),
    .wb_sel_i     (wb_sel_i),
    .wb_adr_i     (wb_adr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_dat_o     (wb_dat_o),
    .wb_ack_o     (wb_ack_o),
    .wb_err_o     (wb_err_o),
    .epb_cs_n     (epb_cs_n),
    .epb_oe_n     (epb_oe_n),
    .epb_r_w_n    (epb_r_w_n),
    .epb_be_n     (epb_be_n),
    .epb_addr     (epb_addr),
    .epb_data_o   (epb_data_o),
    .epb_data_oe_n(epb_data_oe_n),
    .epb_data_i   (epb_data_i),
    .epb_rdy      (epb_rdy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Runs one Wishbone request. The target pulses epb_rdy so that it is sampled d+1 edges after
  // the request edge; abort_k > 0 drops cyc/stb before edge k. Results in k = edges after request.
  task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int d, input logic [31:0] rdata,
                         input int abort_k);
    ack_k = -1; err_k = -1; n_ack = 0; n_err = 0; cs_at_done = 1'bx; dat_at_ack = 'x;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    tick();
    s_cs = epb_cs_n; s_oe = epb_oe_n; s_doe = epb_data_oe_n; s_rw = epb_r_w_n;
    s_be = epb_be_n; s_addr = epb_addr; s_dout = epb_data_o;
    for (int k = 1; k <= TO + 3; k++) begin
      if (abort_k > 0 && k >= abort_k) begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      epb_rdy    = (k == d + 1);
      epb_data_i = (k == d + 1) ? rdata : ~rdata;
      tick();
      if (wb_ack_o) begin
        n_ack++; ack_k = k; dat_at_ack = wb_dat_o; cs_at_done = epb_cs_n;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      if (wb_err_o) begin
        n_err++; err_k = k; cs_at_done = epb_cs_n;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
    end
    epb_rdy = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    dat_at_end = wb_dat_o;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 0; wb_adr_i = 0; wb_dat_i = 0;
    epb_data_i = 0; epb_rdy = 0;
    #2;
    checks++; if ({epb_cs_n, epb_oe_n, epb_r_w_n, epb_data_oe_n} !== 4'hF) begin
      errors++; $display("FAIL reset_ctrl: got %b want 1111",
                         {epb_cs_n, epb_oe_n, epb_r_w_n, epb_data_oe_n}); end
    checks++; if (epb_be_n !== 4'hF) begin
      errors++; $display("FAIL reset_be_n: got %h want f", epb_be_n); end
    checks++; if ({epb_addr, epb_data_o, wb_dat_o} !== '0) begin
      errors++; $display("FAIL reset_buses: addr %h data_o %h dat_o %h want 0",
                         epb_addr, epb_data_o, wb_dat_o); end
    checks++; if ({wb_ack_o, wb_err_o} !== 2'b00) begin
      errors++; $display("FAIL reset_ack_err: got %b want 00", {wb_ack_o, wb_err_o}); end
    tick(); tick();
    wb_rst_i = 1'b0;
    model_dat = '0;
    tick();
  endtask

  task automatic test_write();
    do_xfer(1'b1, 32'h0000_0104, 32'hA5A5_1234, 4'b0011, 2, 32'h0, 0);
    checks++; if (s_addr !== 25'h41) begin
      errors++; $display("FAIL wr_addr: got %h want 41", s_addr); end
    checks++; if (s_be !== 4'b1100) begin
      errors++; $display("FAIL wr_be_n: got %b want 1100", s_be); end
    checks++; if ({s_cs, s_rw, s_doe, s_oe} !== 4'b0001) begin
      errors++; $display("FAIL wr_ctrl cs/rw/doe/oe: got %b want 0001", {s_cs, s_rw, s_doe, s_oe}); end
    checks++; if (s_dout !== 32'hA5A5_1234) begin
      errors++; $display("FAIL wr_data_o: got %h want a5a51234", s_dout); end
    // rdy sampled 3 edges after the request edge, ack visible right after that edge
    checks++; if (n_ack !== 1 || ack_k !== 3 || n_err !== 0) begin
      errors++; $display("FAIL wr_ack: got n=%0d k=%0d err=%0d want n=1 k=3 err=0",
                         n_ack, ack_k, n_err); end
    checks++; if (cs_at_done !== 1'b1) begin
      errors++; $display("FAIL wr_cs_at_ack: got %b want 1", cs_at_done); end
    checks++; if (dat_at_end !== model_dat) begin
      errors++; $display("FAIL wr_dat_o_kept: got %h want %h", dat_at_end, model_dat); end
  endtask

  task automatic test_read();
    do_xfer(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 0);
    model_dat = 32'hDEAD_BEEF;
    checks++; if ({s_cs, s_oe, s_doe, s_rw} !== 4'b0011 || s_addr !== 25'h4) begin
      errors++; $display("FAIL rd_ctrl cs/oe/doe/rw: got %b addr %h want 0011 addr 4",
                         {s_cs, s_oe, s_doe, s_rw}, s_addr); end
    checks++; if (n_ack !== 1 || ack_k !== 1) begin
      errors++; $display("FAIL rd_min_ack: got n=%0d k=%0d want n=1 k=1", n_ack, ack_k); end
    checks++; if (dat_at_ack !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_data: got %h want deadbeef", dat_at_ack); end
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, 50, 32'h1111_2222, 0);
    // err visible right after the TO-th edge following the request edge
    checks++; if (n_err !== 1 || err_k !== TO || n_ack !== 0) begin
      errors++; $display("FAIL to_err: got n=%0d k=%0d ack=%0d want n=1 k=%0d ack=0",
                         n_err, err_k, n_ack, TO); end
    checks++; if (cs_at_done !== 1'b1) begin
      errors++; $display("FAIL to_cs_at_err: got %b want 1", cs_at_done); end
    checks++; if (dat_at_end !== model_dat) begin
      errors++; $display("FAIL to_dat_o_kept: got %h want %h", dat_at_end, model_dat); end
    do_xfer(1'b0, 32'h0000_0204, 32'h0, 4'hF, TO - 1, 32'h3333_4444, 0);
    model_dat = 32'h3333_4444;
    checks++; if (n_ack !== 1 || ack_k !== TO || n_err !== 0) begin
      errors++; $display("FAIL to_race: got ack=%0d k=%0d err=%0d want ack=1 k=%0d err=0",
                         n_ack, ack_k, n_err, TO); end
    checks++; if (dat_at_ack !== 32'h3333_4444) begin
      errors++; $display("FAIL to_race_data: got %h want 33334444", dat_at_ack); end
  endtask

  task automatic test_abort();
    do_xfer(1'b0, 32'h0000_0300, 32'h0, 4'hF, 3, 32'h5555_6666, 2);
    // The read still completes on the EPB side, so the data register is updated.
    model_dat = 32'h5555_6666;
    checks++; if (n_ack !== 0 || n_err !== 0) begin
      errors++; $display("FAIL abort_rdy: got ack=%0d err=%0d want 0 0", n_ack, n_err); end
    checks++; if (epb_cs_n !== 1'b1) begin
      errors++; $display("FAIL abort_cs_idle: got %b want 1", epb_cs_n); end
    do_xfer(1'b1, 32'h0000_0304, 32'h0BAD_F00D, 4'hF, 40, 32'h0, 3);
    checks++; if (n_ack !== 0 || n_err !== 0) begin
      errors++; $display("FAIL abort_timeout: got ack=%0d err=%0d want 0 0", n_ack, n_err); end
    do_xfer(1'b0, 32'h0000_0308, 32'h0, 4'hF, 1, 32'h7777_8888, 0);
    model_dat = 32'h7777_8888;
    checks++; if (n_ack !== 1 || ack_k !== 2 || dat_at_ack !== 32'h7777_8888) begin
      errors++; $display("FAIL abort_next: got n=%0d k=%0d dat=%h want n=1 k=2 dat=77778888",
                         n_ack, ack_k, dat_at_ack); end
  endtask

  task automatic test_back_to_back();
    logic hist[$];
    int acks = 0, low_cnt = 0, phase = 0, gap = 0, low_runs = 0;
    logic [31:0] rd = 32'h1234_5678;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 32'h0000_0400; wb_sel_i = 4'hF;
    epb_data_i = rd;
    for (int i = 0; i < 30; i++) begin
      epb_rdy = (low_cnt == 2);
      tick();
      hist.push_back(epb_cs_n);
      if (epb_cs_n == 1'b0) low_cnt++; else low_cnt = 0;
      if (wb_ack_o) begin
        acks++;
        checks++; if (wb_dat_o !== rd) begin
          errors++; $display("FAIL b2b_data: got %h want %h", wb_dat_o, rd); end
        if (acks == 2) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
      end
    end
    epb_rdy = 1'b0;
    model_dat = rd;
    foreach (hist[i]) begin
      if (hist[i] == 1'b0 && (i == 0 || hist[i-1] == 1'b1)) low_runs++;
      case (phase)
        0: if (hist[i] == 1'b0) phase = 1;
        1: if (hist[i] == 1'b1) begin phase = 2; gap = 1; end
        2: if (hist[i] == 1'b1) gap++; else phase = 3;
        default: ;
      endcase
    end
    checks++; if (acks !== 2) begin
      errors++; $display("FAIL b2b_acks: got %0d want 2", acks); end
    checks++; if (gap !== 2 || low_runs !== 2) begin
      errors++; $display("FAIL b2b_cs_gap: got gap=%0d runs=%0d want gap=2 runs=2",
                         gap, low_runs); end
  endtask

  task automatic test_random();
    logic        we;
    logic [31:0] adr, dat, rdata;
    logic [3:0]  sel;
    int          d;
    bit          exp_ack;
    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom); adr = $urandom; dat = $urandom; rdata = $urandom;
      sel = 4'($urandom); d = $urandom_range(0, TO + 1);
      do_xfer(we, adr, dat, sel, d, rdata, 0);
      exp_ack = (d < TO);
      if (exp_ack && !we) model_dat = rdata;
      checks++; if (s_addr !== adr[26:2] || s_be !== ~sel || s_rw !== ~we ||
                    s_dout !== dat) begin
        errors++; $display("FAIL rnd_map[%0d]: addr %h be %b rw %b dout %h want %h %b %b %h",
                           n, s_addr, s_be, s_rw, s_dout, adr[26:2], ~sel, ~we, dat); end
      checks++; if ({s_cs, s_oe, s_doe} !== {1'b0, we, ~we}) begin
        errors++; $display("FAIL rnd_ctrl[%0d]: cs/oe/doe got %b want %b",
                           n, {s_cs, s_oe, s_doe}, {1'b0, we, ~we}); end
      checks++; if (exp_ack ? (n_ack !== 1 || ack_k !== d + 1 || n_err !== 0)
                            : (n_err !== 1 || err_k !== TO || n_ack !== 0)) begin
        errors++; $display("FAIL rnd_done[%0d]: ack=%0d@%0d err=%0d@%0d d=%0d", n,
                           n_ack, ack_k, n_err, err_k, d); end
      checks++; if (dat_at_end !== model_dat) begin
        errors++; $display("FAIL rnd_dat_o[%0d]: got %h want %h", n, dat_at_end, model_dat); end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h0000_0FFC; wb_dat_i = 32'hCAFE_0001; wb_sel_i = 4'h5;
    tick(); tick(); tick();
    #2 wb_rst_i = 1'b1;
    #1;
    checks++; if ({epb_cs_n, epb_oe_n, epb_r_w_n, epb_data_oe_n, epb_be_n} !== 8'hFF) begin
      errors++; $display("FAIL rstmid_ctrl: got %b want 11111111",
                         {epb_cs_n, epb_oe_n, epb_r_w_n, epb_data_oe_n, epb_be_n}); end
    checks++; if ({epb_addr, epb_data_o, wb_dat_o, wb_ack_o, wb_err_o} !== '0) begin
      errors++; $display("FAIL rstmid_buses: addr %h data_o %h dat_o %h ack %b err %b",
                         epb_addr, epb_data_o, wb_dat_o, wb_ack_o, wb_err_o); end
    tick();
    wb_rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    for (int k = 0; k < TO + 4; k++) begin
      epb_rdy = (k == 1);
      tick();
      if (wb_ack_o || wb_err_o) seen++;
    end
    epb_rdy = 1'b0;
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL rstmid_no_pulse: got %0d pulses want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
